lcd_responder: RTL and testbench

- Synthesizable HD44780-compatible responder: the display end of the 8-bit parallel LCD bus (LCD_DATA/RS/RW/EN).
- Samples controller bus cycles and decodes commands and data writes into an 80-byte DDRAM (2 lines × 40).
- Models the busy flag and answers read cycles.
- Exposes the 2×16 visible window to on-chip logic. Used as an on-FPGA loopback target and as a verification partner for our LCD writer blocks.

---
 rtl/lcd_pkg.sv | 62 ++++++
 rtl/lcd_ddram.sv | 31 +++
 rtl/lcd_responder.sv | 182 ++++++++++++++++++
 tb/tb_lcd_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, types and address helpers for the HD44780-style LCD responder.
package lcd_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 80;

    localparam logic [ADDR_W-1:0] LINE1_BASE = 7'h00;
    localparam logic [ADDR_W-1:0] LINE2_BASE = 7'h40;
    localparam int unsigned       LINE_LEN   = 40;
    localparam logic [ADDR_W-1:0] LINE1_LAST = LINE1_BASE + ADDR_W'(LINE_LEN - 1);
    localparam logic [ADDR_W-1:0] LINE2_LAST = LINE2_BASE + ADDR_W'(LINE_LEN - 1);
    localparam logic [DATA_W-1:0] CHAR_SPACE = 8'h20;

    // Instruction opcodes: the leading set bit selects the command
    localparam logic [DATA_W-1:0] CMD_CLEAR = 8'h01;
    localparam logic [DATA_W-1:0] CMD_HOME  = 8'h02;
    localparam logic [DATA_W-1:0] CMD_ENTRY = 8'h04;
    localparam logic [DATA_W-1:0] CMD_DISP  = 8'h08;
    localparam logic [DATA_W-1:0] CMD_SHIFT = 8'h10;
    localparam logic [DATA_W-1:0] CMD_FUNC  = 8'h20;
    localparam logic [DATA_W-1:0] CMD_CGRAM = 8'h40;
    localparam logic [DATA_W-1:0] CMD_DDRAM = 8'h80;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_IDLE,
        ST_BUSY
    } state_e;

    typedef struct packed {
        logic              rs;
        logic              rw;
        logic [DATA_W-1:0] data;
    } bus_t;

    // Address counter step with the two-line wrap points
    function automatic logic [ADDR_W-1:0] ac_step(input logic [ADDR_W-1:0] a, input logic inc);
        if (inc) begin
            if (a == LINE1_LAST) return LINE2_BASE;
            if (a == LINE2_LAST) return LINE1_BASE;
            return a + ADDR_W'(1);
        end
        if (a == LINE1_BASE) return LINE2_LAST;
        if (a == LINE2_BASE) return LINE1_LAST;
        return a - ADDR_W'(1);
    endfunction

    function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
        return (a <= LINE1_LAST) || ((a >= LINE2_BASE) && (a <= LINE2_LAST));
    endfunction

    // DDRAM address to packed RAM row (line 2 follows line 1)
    function automatic logic [ADDR_W-1:0] ram_index(input logic [ADDR_W-1:0] a);
        return a[6] ? ADDR_W'(LINE_LEN) + ADDR_W'({1'b0, a[5:0]}) : ADDR_W'({1'b0, a[5:0]});
    endfunction

    function automatic logic [ADDR_W-1:0] view_to_addr(input logic [4:0] v);
        return {v[4], 2'b00, v[3:0]};
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80x8 display RAM: one synchronous write port, async bus read, registered view read.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic              iclk,
    input  logic              irst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_c,
    input  logic [ADDR_W-1:0] vaddr_i,
    output logic [DATA_W-1:0] vdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] vdata_q;

    always_ff @(posedge iclk) begin
        if (we_i) mem_q[ram_index(waddr_i)] <= wdata_i;
    end

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) vdata_q <= '0;
        else       vdata_q <= mem_q[ram_index(vaddr_i)];
    end

    assign rdata_c = mem_q[ram_index(raddr_i)];
    assign vdata_o = vdata_q;

endmodule

// File: rtl/lcd_responder.sv
// Display end of an 8-bit HD44780 bus: decodes controller cycles into DDRAM and
// control state, models the busy flag and answers read cycles.
module lcd_responder
    import lcd_pkg::*;
#(
    parameter int unsigned BUSY_SHORT = 1850,
    parameter int unsigned BUSY_LONG  = 76000
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic [DATA_W-1:0] LCD_DATA,
    input  logic              LCD_RW,
    input  logic              LCD_EN,
    input  logic              LCD_RS,
    output logic [DATA_W-1:0] lcd_dout,
    output logic              lcd_doe,
    input  logic [4:0]        view_addr,
    output logic [DATA_W-1:0] view_data,
    output logic              disp_on,
    output logic              cursor_on,
    output logic              blink_on,
    output logic [2:0]        func_cfg,
    output logic              entry_id,
    output logic [ADDR_W-1:0] ac,
    output logic              busy,
    output logic              ovr_err,
    output logic              addr_err,
    input  logic              err_clr
);

    localparam int unsigned CNT_MAX = (BUSY_LONG > BUSY_SHORT) ? BUSY_LONG : BUSY_SHORT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    bus_t              bus_s1_q, bus_s2_q;
    logic              en_s1_q, en_s2_q, en_d1_q;
    logic              ev_c;
    state_e            state_q;
    logic [ADDR_W-1:0] fill_addr_q, ac_q, waddr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q, entry_q, ovr_q, aerr_q, doe_q, we_q;
    logic [2:0]        disp_q, func_q;
    logic [DATA_W-1:0] dout_q, wdata_q, ram_rdata_c;

    // Two-flop synchronizers; the event is the falling edge of synced EN
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            en_s1_q  <= 1'b0;
            en_s2_q  <= 1'b0;
            en_d1_q  <= 1'b0;
            bus_s1_q <= '0;
            bus_s2_q <= '0;
        end else begin
            en_s1_q  <= LCD_EN;
            en_s2_q  <= en_s1_q;
            en_d1_q  <= en_s2_q;
            bus_s1_q <= {LCD_RS, LCD_RW, LCD_DATA};
            bus_s2_q <= bus_s1_q;
        end
    end

    assign ev_c = en_d1_q & ~en_s2_q;

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            state_q     <= ST_FILL;
            fill_addr_q <= LINE1_BASE;
            cnt_q       <= CNT_W'(BUSY_LONG);
            busy_q      <= 1'b1;
            ac_q        <= '0;
            entry_q     <= 1'b1;
            disp_q      <= 3'b000;
            func_q      <= 3'b110;
            ovr_q       <= 1'b0;
            aerr_q      <= 1'b0;
            doe_q       <= 1'b0;
            dout_q      <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            we_q <= 1'b0;
            if (err_clr) begin
                ovr_q  <= 1'b0;
                aerr_q <= 1'b0;
            end
            if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);

            if (en_s2_q && bus_s2_q.rw) begin
                doe_q  <= 1'b1;
                dout_q <= bus_s2_q.rs ? ram_rdata_c : {busy_q, ac_q};
            end else begin
                doe_q  <= 1'b0;
            end

            case (state_q)
                ST_FILL: begin
                    we_q        <= 1'b1;
                    waddr_q     <= fill_addr_q;
                    wdata_q     <= CHAR_SPACE;
                    fill_addr_q <= ac_step(fill_addr_q, 1'b1);
                    if (fill_addr_q == LINE2_LAST) state_q <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: ;
                default: state_q <= ST_IDLE;
            endcase

            // Bus event: writes only when idle, data reads step the counter at any time
            if (ev_c) begin
                if (!bus_s2_q.rw) begin
                    if (state_q != ST_IDLE) begin
                        ovr_q <= 1'b1;
                    end else begin
                        busy_q  <= 1'b1;
                        state_q <= ST_BUSY;
                        cnt_q   <= CNT_W'(BUSY_SHORT);
                        if (bus_s2_q.rs) begin
                            we_q    <= 1'b1;
                            waddr_q <= ac_q;
                            wdata_q <= bus_s2_q.data;
                            ac_q    <= ac_step(ac_q, entry_q);
                        end else if (|(bus_s2_q.data & CMD_DDRAM)) begin
                            if (addr_legal(bus_s2_q.data[6:0])) ac_q <= bus_s2_q.data[6:0];
                            else                                aerr_q <= 1'b1;
                        end else if (|(bus_s2_q.data & CMD_CGRAM)) begin
                            aerr_q <= 1'b1;
                        end else if (|(bus_s2_q.data & CMD_FUNC)) begin
                            func_q <= bus_s2_q.data[4:2];
                        end else if (|(bus_s2_q.data & CMD_SHIFT)) begin
                            if (!bus_s2_q.data[3]) ac_q <= ac_step(ac_q, bus_s2_q.data[2]);
                        end else if (|(bus_s2_q.data & CMD_DISP)) begin
                            disp_q <= bus_s2_q.data[2:0];
                        end else if (|(bus_s2_q.data & CMD_ENTRY)) begin
                            entry_q <= bus_s2_q.data[1];
                        end else if (|(bus_s2_q.data & CMD_HOME)) begin
                            ac_q  <= '0;
                            cnt_q <= CNT_W'(BUSY_LONG);
                        end else if (|(bus_s2_q.data & CMD_CLEAR)) begin
                            ac_q        <= '0;
                            entry_q     <= 1'b1;
                            cnt_q       <= CNT_W'(BUSY_LONG);
                            fill_addr_q <= LINE1_BASE;
                            state_q     <= ST_FILL;
                        end
                    end
                end else if (bus_s2_q.rs) begin
                    ac_q <= ac_step(ac_q, entry_q);
                end
            end
        end
    end

    lcd_ddram u_ddram (
        .iclk    (iclk),
        .irst    (irst),
        .we_i    (we_q),
        .waddr_i (waddr_q),
        .wdata_i (wdata_q),
        .raddr_i (ac_q),
        .rdata_c (ram_rdata_c),
        .vaddr_i (view_to_addr(view_addr)),
        .vdata_o (view_data)
    );

    assign lcd_dout  = dout_q;
    assign lcd_doe   = doe_q;
    assign disp_on   = disp_q[2];
    assign cursor_on = disp_q[1];
    assign blink_on  = disp_q[0];
    assign func_cfg  = func_q;
    assign entry_id  = entry_q;
    assign ac        = ac_q;
    assign busy      = busy_q;
    assign ovr_err   = ovr_q;
    assign addr_err  = aerr_q;

endmodule

// File: tb/tb_lcd_responder.sv
// Directed bench for lcd_responder: instruction/data vector table plus hand sequences
// for boot fill, reads, overrun, clear and reset mid-operation.
module tb_lcd_responder;

    localparam int unsigned SHORT = 200;
    localparam int unsigned LONG  = 400;

    logic       iclk, irst;
    logic [7:0] LCD_DATA;
    logic       LCD_RW, LCD_EN, LCD_RS;
    logic [7:0] lcd_dout;
    logic       lcd_doe;
    logic [4:0] view_addr;
    logic [7:0] view_data;
    logic       disp_on, cursor_on, blink_on;
    logic [2:0] func_cfg;
    logic       entry_id;
    logic [6:0] ac;
    logic       busy, ovr_err, addr_err, err_clr;

    int n_vec = 0;
    int n_err = 0;

    lcd_responder #(.BUSY_SHORT(SHORT), .BUSY_LONG(LONG)) dut (
        .iclk(iclk), .irst(irst), .LCD_DATA(LCD_DATA), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
        .LCD_RS(LCD_RS), .lcd_dout(lcd_dout), .lcd_doe(lcd_doe), .view_addr(view_addr),
        .view_data(view_data), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .func_cfg(func_cfg), .entry_id(entry_id), .ac(ac), .busy(busy), .ovr_err(ovr_err),
        .addr_err(addr_err), .err_clr(err_clr)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    typedef struct {
        logic        rs;
        logic [7:0]  d;
        logic        clr;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [26];

    function automatic logic [15:0] st(input logic e, input logic i, input logic [2:0] f,
                                       input logic [2:0] dcb, input logic [6:0] a);
        return {1'b0, e, i, f, dcb, a};
    endfunction

    function automatic logic [15:0] status();
        return {ovr_err, addr_err, entry_id, func_cfg, disp_on, cursor_on, blink_on, ac};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Write/idle bus cycle; clr_ev raises err_clr exactly on the decode cycle
    task automatic bus_cycle(input logic rs, input logic [7:0] d, input logic clr_ev);
        @(negedge iclk);
        LCD_RW = 1'b0; LCD_RS = rs; LCD_DATA = d; LCD_EN = 1'b1;
        repeat (4) @(negedge iclk);
        LCD_EN = 1'b0;
        repeat (2) @(negedge iclk);
        if (clr_ev) err_clr = 1'b1;
        @(negedge iclk);
        err_clr = 1'b0;
        repeat (2) @(negedge iclk);
    endtask

    task automatic bus_read(input logic rs, input logic [7:0] exp, input string nm);
        @(negedge iclk);
        LCD_RW = 1'b1; LCD_RS = rs; LCD_EN = 1'b1;
        repeat (4) @(negedge iclk);
        chk({nm, " doe"}, 32'(lcd_doe), 32'(1));
        chk({nm, " dout"}, 32'(lcd_dout), 32'(exp));
        LCD_EN = 1'b0;
        repeat (5) @(negedge iclk);
        chk({nm, " doe off"}, 32'(lcd_doe), 32'(0));
        LCD_RW = 1'b0; LCD_RS = 1'b0;
    endtask

    task automatic view_chk(input logic [4:0] a, input logic [7:0] exp);
        @(negedge iclk);
        view_addr = a;
        @(negedge iclk);
        chk($sformatf("view %0d", a), 32'(view_data), 32'(exp));
    endtask

    task automatic boot_count(input string nm);
        int n;
        n = 0;
        while (busy && n < int'(LONG) + 100) begin
            @(posedge iclk);
            #1;
            n++;
        end
        chk(nm, 32'(n), 32'(LONG));
    endtask

    task automatic rst_chk(input string nm);
        chk({nm, " status"}, 32'(status()), 32'(st(1'b0, 1'b1, 3'b110, 3'b000, 7'h00)));
        chk({nm, " busy"}, 32'(busy), 32'(1));
        chk({nm, " bus/view"}, 32'({lcd_doe, lcd_dout, view_data}), 32'(0));
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        irst = 1'b0; LCD_DATA = '0; LCD_RW = 1'b0; LCD_EN = 1'b0; LCD_RS = 1'b0;
        view_addr = '0; err_clr = 1'b0;

        tbl[0]  = '{1'b0, 8'h38, 1'b0, st(0, 1, 3'b110, 3'b000, 7'h00)};
        tbl[1]  = '{1'b0, 8'h0C, 1'b0, st(0, 1, 3'b110, 3'b100, 7'h00)};
        tbl[2]  = '{1'b0, 8'h01, 1'b0, st(0, 1, 3'b110, 3'b100, 7'h00)};
        tbl[3]  = '{1'b0, 8'h06, 1'b0, st(0, 1, 3'b110, 3'b100, 7'h00)};
        tbl[4]  = '{1'b0, 8'h80, 1'b0, st(0, 1, 3'b110, 3'b100, 7'h00)};
        tbl[5]  = '{1'b1, 8'h4C, 1'b0, st(0, 1, 3'b110, 3'b100, 7'h01)};
        tbl[6]  = '{1'b1, 8'h43, 1'b0, st(0, 1, 3'b110, 3'b100, 7'h02)};
        tbl[7]  = '{1'b1, 8'h44, 1'b0, st(0, 1, 3'b110, 3'b100, 7'h03)};
        tbl[8]  = '{1'b0, 8'hA7, 1'b0, st(0, 1, 3'b110, 3'b100, 7'h27)};
        tbl[9]  = '{1'b1, 8'h41, 1'b0, st(0, 1, 3'b110, 3'b100, 7'h40)};
        tbl[10] = '{1'b1, 8'h42, 1'b0, st(0, 1, 3'b110, 3'b100, 7'h41)};
        tbl[11] = '{1'b0, 8'hA8, 1'b0, st(1, 1, 3'b110, 3'b100, 7'h41)};
        tbl[12] = '{1'b0, 8'h10, 1'b1, st(0, 1, 3'b110, 3'b100, 7'h40)};
        tbl[13] = '{1'b0, 8'h10, 1'b0, st(0, 1, 3'b110, 3'b100, 7'h27)};
        tbl[14] = '{1'b0, 8'h14, 1'b0, st(0, 1, 3'b110, 3'b100, 7'h40)};
        tbl[15] = '{1'b0, 8'h04, 1'b0, st(0, 0, 3'b110, 3'b100, 7'h40)};
        tbl[16] = '{1'b0, 8'h1C, 1'b0, st(0, 0, 3'b110, 3'b100, 7'h40)};
        tbl[17] = '{1'b0, 8'h0F, 1'b0, st(0, 0, 3'b110, 3'b111, 7'h40)};
        tbl[18] = '{1'b0, 8'h02, 1'b0, st(0, 0, 3'b110, 3'b111, 7'h00)};
        tbl[19] = '{1'b0, 8'h10, 1'b0, st(0, 0, 3'b110, 3'b111, 7'h67)};
        tbl[20] = '{1'b0, 8'h14, 1'b0, st(0, 0, 3'b110, 3'b111, 7'h00)};
        tbl[21] = '{1'b0, 8'h40, 1'b0, st(1, 0, 3'b110, 3'b111, 7'h00)};
        tbl[22] = '{1'b0, 8'h3C, 1'b1, st(0, 0, 3'b111, 3'b111, 7'h00)};
        tbl[23] = '{1'b0, 8'hE7, 1'b0, st(0, 0, 3'b111, 3'b111, 7'h67)};
        tbl[24] = '{1'b1, 8'h5A, 1'b0, st(0, 0, 3'b111, 3'b111, 7'h66)};
        tbl[25] = '{1'b0, 8'h06, 1'b0, st(0, 1, 3'b111, 3'b111, 7'h66)};

        repeat (3) @(negedge iclk);
        rst_chk("reset");
        irst = 1'b1;
        boot_count("boot busy cycles");
        view_chk(5'd0, 8'h20);
        view_chk(5'd15, 8'h20);
        view_chk(5'd16, 8'h20);
        view_chk(5'd31, 8'h20);

        for (int i = 0; i < 26; i++) begin
            bus_cycle(tbl[i].rs, tbl[i].d, tbl[i].clr);
            repeat (LONG + 20) @(negedge iclk);
            chk($sformatf("vec %0d status", i), 32'(status()), 32'(tbl[i].exp));
            chk($sformatf("vec %0d busy", i), 32'(busy), 32'(0));
        end

        view_chk(5'd0, 8'h4C);
        view_chk(5'd1, 8'h43);
        view_chk(5'd2, 8'h44);
        view_chk(5'd3, 8'h20);
        view_chk(5'd16, 8'h42);
        view_chk(5'd17, 8'h20);

        // Data reads step ac with wrap; DDRAM[0x67] and [0x27] only visible via the bus
        bus_cycle(1'b0, 8'hE7, 1'b0);
        repeat (LONG + 20) @(negedge iclk);
        bus_read(1'b1, 8'h5A, "rd 67");
        chk("ac after rd 67", 32'(ac), 32'(7'h00));
        bus_read(1'b1, 8'h4C, "rd 00");
        chk("ac after rd 00", 32'(ac), 32'(7'h01));
        bus_cycle(1'b0, 8'hA7, 1'b0);
        repeat (LONG + 20) @(negedge iclk);
        bus_read(1'b1, 8'h41, "rd 27");
        chk("ac after rd 27", 32'(ac), 32'(7'h40));
        bus_read(1'b1, 8'h42, "rd 40");
        chk("ac after rd 40", 32'(ac), 32'(7'h41));

        // Overrun: second write inside the short busy window, err_clr on the same cycle
        bus_cycle(1'b0, 8'h85, 1'b0);
        repeat (LONG + 20) @(negedge iclk);
        chk("ac set 05", 32'(ac), 32'(7'h05));
        bus_cycle(1'b1, 8'h31, 1'b0);
        repeat (100) @(negedge iclk);
        bus_cycle(1'b1, 8'h32, 1'b1);
        chk("ovr set wins over clr", 32'(ovr_err), 32'(1));
        chk("ac after dropped write", 32'(ac), 32'(7'h06));
        bus_read(1'b0, 8'h86, "rd status busy");
        repeat (SHORT + 20) @(negedge iclk);
        chk("busy after overrun", 32'(busy), 32'(0));
        chk("ovr sticky", 32'(ovr_err), 32'(1));
        err_clr = 1'b1;
        @(negedge iclk);
        err_clr = 1'b0;
        @(negedge iclk);
        chk("ovr cleared", 32'(ovr_err), 32'(0));
        view_chk(5'd5, 8'h31);
        view_chk(5'd6, 8'h20);

        // Clear refills with spaces and homes ac
        bus_cycle(1'b0, 8'h01, 1'b0);
        repeat (LONG + 20) @(negedge iclk);
        chk("ac after clear", 32'(ac), 32'(7'h00));
        view_chk(5'd0, 8'h20);
        view_chk(5'd5, 8'h20);
        view_chk(5'd16, 8'h20);
        bus_cycle(1'b1, 8'h55, 1'b0);
        repeat (SHORT + 20) @(negedge iclk);
        view_chk(5'd0, 8'h55);
        chk("ac after 55", 32'(ac), 32'(7'h01));

        // Reset in the middle of a busy period restarts the power-on fill
        bus_cycle(1'b0, 8'h06, 1'b0);
        repeat (20) @(negedge iclk);
        irst = 1'b0;
        @(negedge iclk);
        rst_chk("mid reset");
        irst = 1'b1;
        boot_count("reboot busy cycles");
        view_chk(5'd0, 8'h20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
